// File: rtl/tdm_demux4_if.sv
// Bundle for the 4-channel TDM receive link: serial slot stream in, frame-aligned channel words and sync status out.
// The transmitter side drives through master; the demultiplexer binds to slave.
interface tdm_demux4_if #(
  parameter int W     = 8,
  parameter int ERR_W = 8
);
  logic [W-1:0]     din;
  logic             din_valid;
  logic             fsync;
  logic [4*W-1:0]   dout;
  logic             dout_valid;
  logic             locked;
  logic [1:0]       slot;
  logic             sync_err;
  logic [ERR_W-1:0] err_cnt;

  modport master (
    output din, din_valid, fsync,
    input  dout, dout_valid, locked, slot, sync_err, err_cnt
  );

  modport slave (
    input  din, din_valid, fsync,
    output dout, dout_valid, locked, slot, sync_err, err_cnt
  );
endinterface

// File: rtl/tdm_demux4.sv
// Receive side of the 4-channel TDM link: locks to fsync on slot 0 and reassembles four slot samples
// into one parallel frame word, flagging missing or early frame syncs.
module tdm_demux4 #(
  parameter int W     = 8,
  parameter int ERR_W = 8
) (
  input  logic        clk,
  input  logic        rst_n,
  tdm_demux4_if.slave bus
);

  typedef enum logic {
    HUNT,
    LOCKED
  } state_t;

  state_t           state_q, state_nxt;
  logic [1:0]       slot_q, slot_nxt;
  logic [W-1:0]     shadow_q [3];
  logic [W-1:0]     shadow_nxt [3];
  logic [4*W-1:0]   dout_q, dout_nxt;
  logic             dout_valid_q, dout_valid_nxt;
  logic             sync_err_q, sync_err_nxt;
  logic [ERR_W-1:0] err_cnt_q, err_cnt_nxt;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q      <= HUNT;
      slot_q       <= 2'd0;
      shadow_q     <= '{default: '0};
      dout_q       <= '0;
      dout_valid_q <= 1'b0;
      sync_err_q   <= 1'b0;
      err_cnt_q    <= '0;
    end else begin
      state_q      <= state_nxt;
      slot_q       <= slot_nxt;
      shadow_q     <= shadow_nxt;
      dout_q       <= dout_nxt;
      dout_valid_q <= dout_valid_nxt;
      sync_err_q   <= sync_err_nxt;
      err_cnt_q    <= err_cnt_nxt;
    end
  end

  // Slot 3 is never shadowed: it goes straight into dout so the frame word updates in one edge.
  always_comb begin
    state_nxt      = state_q;
    slot_nxt       = slot_q;
    shadow_nxt     = shadow_q;
    dout_nxt       = dout_q;
    dout_valid_nxt = 1'b0;
    sync_err_nxt   = 1'b0;
    err_cnt_nxt    = err_cnt_q;

    if (bus.din_valid) begin
      case (state_q)
        HUNT: begin
          if (bus.fsync) begin
            shadow_nxt[0] = bus.din;
            slot_nxt      = 2'd1;
            state_nxt     = LOCKED;
          end
        end
        LOCKED: begin
          if (slot_q == 2'd0) begin
            if (bus.fsync) begin
              shadow_nxt[0] = bus.din;
              slot_nxt      = 2'd1;
            end else begin
              sync_err_nxt = 1'b1;
              slot_nxt     = 2'd0;
              state_nxt    = HUNT;
            end
          end else if (bus.fsync) begin
            // Early sync: drop the partial frame and restart on this beat.
            sync_err_nxt  = 1'b1;
            shadow_nxt[0] = bus.din;
            slot_nxt      = 2'd1;
          end else if (slot_q == 2'd3) begin
            dout_nxt       = {bus.din, shadow_q[2], shadow_q[1], shadow_q[0]};
            dout_valid_nxt = 1'b1;
            slot_nxt       = 2'd0;
          end else begin
            if (slot_q == 2'd1) begin
              shadow_nxt[1] = bus.din;
            end else begin
              shadow_nxt[2] = bus.din;
            end
            slot_nxt = slot_q + 2'd1;
          end
        end
        default: begin
          state_nxt = HUNT;
          slot_nxt  = 2'd0;
        end
      endcase
    end

    if (sync_err_nxt && (err_cnt_q != {ERR_W{1'b1}})) begin
      err_cnt_nxt = err_cnt_q + ERR_W'(1);
    end
  end

  assign bus.dout       = dout_q;
  assign bus.dout_valid = dout_valid_q;
  assign bus.locked     = (state_q == LOCKED);
  assign bus.slot       = slot_q;
  assign bus.sync_err   = sync_err_q;
  assign bus.err_cnt    = err_cnt_q;

endmodule
